noc_queued_sender: RTL

Buffered, parametrised NoC packet source. Accepts whole packets (destination, padding, payload) into a DEPTH-entry FIFO and serialises each packet onto a `node_port.up` link as header, data and tail flits. Supports back-to-back packets, link stalls during data transfer, and bounded retry with backoff when connection establishment is rejected. Sits between a local producer (accelerator or test pattern source) and a NoC router input port.

---
 rtl/noc_queued_sender_if.sv | 40 ++++
 rtl/noc_queued_sender.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_queued_sender_if.sv
// rtl/noc_queued_sender_if.sv - NoC flit types, header builder and node_port link interface
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 8
`endif

package noc_pkg;
    localparam int FLIT_W    = `FLIT_DATA_WIDTH;
    localparam int ADDR_BITS = 4;

    typedef logic [ADDR_BITS-1:0] addr_t;

    typedef enum logic [1:0] {
        FLIT_HEADER = 2'd0,
        FLIT_DATA   = 2'd1,
        FLIT_TAIL   = 2'd2
    } flit_type_t;

    typedef struct packed {
        flit_type_t           flit_type;
        logic [FLIT_W-1:0]    payload;
    } flit_t;

    // Header payload: destination in the low bits, padding field directly above it.
    function automatic flit_t build_header2(input addr_t dst, input logic [FLIT_W-1:0] padding);
        flit_t f;
        f.flit_type = FLIT_HEADER;
        f.payload   = (padding << ADDR_BITS) | FLIT_W'(dst);
        return f;
    endfunction
endpackage

interface node_port;
    logic           enable;
    noc_pkg::flit_t flit;
    logic           ack;
    logic           rej;

    modport up   (output enable, output flit, input ack, input rej);
    modport down (input enable, input flit, output ack, output rej);
endinterface

// File: rtl/noc_queued_sender.sv
// rtl/noc_queued_sender.sv - FIFO-buffered NoC packet source; NOC_SENDER_RETRY_EN enables reject retry/backoff
module noc_queued_sender
    import noc_pkg::*;
#(
    parameter int PACKET_BITS    = 16,
    parameter int PADDING_BITS   = 0,
    parameter int DEPTH          = 4,
    parameter int MAX_RETRIES    = 3,
    parameter int BACKOFF_CYCLES = 8
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  addr_t                                           dst_addr,
    input  logic [((PADDING_BITS > 0) ? PADDING_BITS : 1)-1:0] padding,
    input  logic [PACKET_BITS-1:0]                          packet,
    output logic [$clog2(DEPTH+1)-1:0]                      level,
    output logic                                            sent,
    output logic                                            dropped,
    node_port.up                                            up
);
    localparam int FW        = FLIT_W;
    localparam int N_FLITS   = (PACKET_BITS + FW - 1) / FW;
    localparam int CNT_W     = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int LVL_W     = $clog2(DEPTH + 1);
    localparam int PAD_W     = (PADDING_BITS > 0) ? PADDING_BITS : 1;
    localparam int PAYLOAD_W = N_FLITS * FW;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_FLITS - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (BACKOFF_CYCLES < 1 || MAX_RETRIES < 0) begin : g_bad_retry
        $error("BACKOFF_CYCLES must be >= 1 and MAX_RETRIES >= 0");
    end

    typedef struct packed {
        addr_t                  dst;
        logic [PAD_W-1:0]       pad;
        logic [PACKET_BITS-1:0] payload;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             new_entry;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    assign new_entry = '{dst: dst_addr, pad: padding, payload: packet};
    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (!push && pop) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    logic [PAYLOAD_W-1:0] padded_payload;
    logic [FW-1:0]        pad_ext;
    flit_t                header_flit;

    assign padded_payload = PAYLOAD_W'(head.payload);
    assign pad_ext        = (PADDING_BITS > 0) ? FW'(head.pad) : '0;
    assign header_flit    = build_header2(head.dst, pad_ext);

`ifdef NOC_SENDER_RETRY_EN
    typedef enum logic [1:0] {S_IDLE, S_ESTABLISHING, S_SENDING, S_BACKOFF} state_t;

    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int BO_W    = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [BO_W-1:0]    BO_LAST   = BO_W'(BACKOFF_CYCLES - 1);

    logic [RETRY_W-1:0] retry_cnt;
    logic [RETRY_W-1:0] retry_cnt_nx;
    logic [BO_W-1:0]    bo_cnt;
    logic [BO_W-1:0]    bo_cnt_nx;
`else
    typedef enum logic [1:0] {S_IDLE, S_ESTABLISHING, S_SENDING} state_t;
`endif

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
`ifdef NOC_SENDER_RETRY_EN
            retry_cnt <= '0;
            bo_cnt    <= '0;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
`ifdef NOC_SENDER_RETRY_EN
            retry_cnt <= retry_cnt_nx;
            bo_cnt    <= bo_cnt_nx;
`endif
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        pop          = 1'b0;
        sent         = 1'b0;
        dropped      = 1'b0;
        up.enable    = 1'b0;
        up.flit      = '0;
`ifdef NOC_SENDER_RETRY_EN
        retry_cnt_nx = retry_cnt;
        bo_cnt_nx    = bo_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    up.enable = 1'b1;
                    up.flit   = header_flit;
                    state_nx  = up.ack ? S_SENDING : S_ESTABLISHING;
                end
            end
            S_ESTABLISHING: begin
                up.enable = 1'b1;
                up.flit   = header_flit;
                if (up.ack) begin
                    state_nx = S_SENDING;
                end else if (up.rej) begin
`ifdef NOC_SENDER_RETRY_EN
                    if (retry_cnt < RETRY_MAX) begin
                        retry_cnt_nx = retry_cnt + RETRY_W'(1);
                        bo_cnt_nx    = '0;
                        state_nx     = S_BACKOFF;
                    end else begin
                        pop          = 1'b1;
                        dropped      = 1'b1;
                        retry_cnt_nx = '0;
                        state_nx     = S_IDLE;
                    end
`else
                    pop      = 1'b1;
                    dropped  = 1'b1;
                    state_nx = S_IDLE;
`endif
                end
            end
            S_SENDING: begin
                // Link stalls simply hold cnt; rej is meaningless once the path is open.
                up.enable         = 1'b1;
                up.flit.flit_type = (cnt == LAST_CNT) ? FLIT_TAIL : FLIT_DATA;
                up.flit.payload   = padded_payload[int'(cnt)*FW +: FW];
                if (up.ack) begin
                    if (cnt == LAST_CNT) begin
                        pop          = 1'b1;
                        sent         = 1'b1;
                        cnt_nx       = '0;
`ifdef NOC_SENDER_RETRY_EN
                        retry_cnt_nx = '0;
`endif
                        state_nx     = S_IDLE;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
`ifdef NOC_SENDER_RETRY_EN
            S_BACKOFF: begin
                if (bo_cnt == BO_LAST) begin
                    state_nx = S_IDLE;
                end else begin
                    bo_cnt_nx = bo_cnt + BO_W'(1);
                end
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end
endmodule
